uart_io_ctrl: RTL and testbench

UART_IO_CTRL -- requirements
Module: uart_io_ctrl

---
 rtl/uart_io_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_io_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: request/response front end for a byte serializer/deserializer pair.
// Transmits 1/2/4-byte little-endian words through a tx valid/ready handshake and assembles
// received bytes from an RX buffer into a zero-extended word.
// Build option: define UART_RX_FIFO_EN for a 2^RX_FIFO_DEPTH_LOG2-byte RX FIFO; otherwise
// the RX buffer is a single-byte holding register.
module uart_io_ctrl #(
    parameter int unsigned RX_FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_order,
    input  logic [1:0]  uart_size,
    input  logic        uart_write,
    input  logic [31:0] uart_o_data,
    output logic        uart_accepted,
    output logic        uart_done,
    output logic [31:0] uart_r_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_overflow
);

    typedef enum logic [1:0] {StIdle, StTx, StRx, StDone} state_e;

    state_e      state_q, state_d;
    logic        accepted_q, accepted_d;
    logic        done_q, done_d;
    logic [31:0] r_data_q, r_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] shreg_q, shreg_d;    // remaining transmit bytes, next byte in [7:0]
    logic [31:0] word_q, word_d;      // receive word under assembly
    logic [1:0]  cnt_q, cnt_d;        // bytes left minus one
    logic [1:0]  idx_q, idx_d;        // receive byte lane
    logic        rx_overflow_q, rx_overflow_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_pop;
    logic        fifo_push;
    logic [7:0]  fifo_head;

    // A full buffer still takes a byte when the same cycle pops one.
    assign fifo_pop  = (state_q == StRx) && !fifo_empty;
    assign fifo_push = rx_valid && (!fifo_full || fifo_pop);

`ifdef UART_RX_FIFO_EN
    localparam int unsigned Depth = 1 << RX_FIFO_DEPTH_LOG2;
    localparam int unsigned PtrW  = RX_FIFO_DEPTH_LOG2;

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW:0]   count_q, count_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PtrW + 1)'(Depth));
    assign fifo_head  = mem_q[rptr_q];

    // Pointer and occupancy update; pointers wrap naturally at the depth.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (fifo_push) wptr_d = wptr_q + 1'b1;
        if (fifo_pop)  rptr_d = rptr_q + 1'b1;
        unique case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (fifo_push) mem_q[wptr_q] <= rx_data;
    end
`else
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_q, hold_d;
    // The depth parameter has no effect in the holding-register build.
    logic       unused_depth_log2;

    assign unused_depth_log2 = ^RX_FIFO_DEPTH_LOG2;
    assign fifo_empty = !hold_valid_q;
    assign fifo_full  = hold_valid_q;
    assign fifo_head  = hold_q;

    // Single-byte holding register next state.
    always_comb begin
        hold_d       = fifo_push ? rx_data : hold_q;
        hold_valid_d = hold_valid_q;
        if (fifo_push)     hold_valid_d = 1'b1;
        else if (fifo_pop) hold_valid_d = 1'b0;
    end

    // Holding register state; reset empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end
`endif

    // Request FSM next state and registered outputs.
    always_comb begin
        state_d       = state_q;
        accepted_d    = 1'b0;
        done_d        = 1'b0;
        r_data_d      = '0;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        shreg_d       = shreg_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rx_overflow_d = rx_overflow_q | (rx_valid & fifo_full & ~fifo_pop);

        unique case (state_q)
            StIdle: begin
                if (uart_order) begin
                    accepted_d = 1'b1;
                    shreg_d    = uart_o_data;
                    word_d     = '0;
                    idx_d      = '0;
                    unique case (uart_size)
                        2'b10:   cnt_d = 2'd0;
                        2'b01:   cnt_d = 2'd1;
                        default: cnt_d = 2'd3;
                    endcase
                    state_d = uart_write ? StTx : StRx;
                end
            end
            StTx: begin
                if (!tx_valid_q) begin
                    // First byte is offered one cycle after acceptance.
                    tx_valid_d = 1'b1;
                    tx_data_d  = shreg_q[7:0];
                    shreg_d    = shreg_q >> 8;
                end else if (tx_ready) begin
                    if (cnt_q == 2'd0) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                        state_d    = StDone;
                    end else begin
                        tx_data_d = shreg_q[7:0];
                        shreg_d   = shreg_q >> 8;
                        cnt_d     = cnt_q - 2'd1;
                    end
                end
            end
            StRx: begin
                if (fifo_pop) begin
                    word_d[{idx_q, 3'b000} +: 8] = fifo_head;
                    if (cnt_q == 2'd0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StDone: begin
                // word_q is cleared on acceptance, so writes report zero.
                done_d   = 1'b1;
                r_data_d = word_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            accepted_q    <= 1'b0;
            done_q        <= 1'b0;
            r_data_q      <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            shreg_q       <= '0;
            word_q        <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            accepted_q    <= accepted_d;
            done_q        <= done_d;
            r_data_q      <= r_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            shreg_q       <= shreg_d;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign uart_accepted = accepted_q;
    assign uart_done     = done_q;
    assign uart_r_data   = r_data_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign rx_overflow   = rx_overflow_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed self-checking bench for uart_io_ctrl.
module tb_uart_io_ctrl;

`ifdef UART_RX_FIFO_EN
    localparam int Depth = 16;
`else
    localparam int Depth = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_order;
    logic [1:0]  uart_size;
    logic        uart_write;
    logic [31:0] uart_o_data;
    logic        uart_accepted;
    logic        uart_done;
    logic [31:0] uart_r_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_io_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .uart_order   (uart_order),
        .uart_size    (uart_size),
        .uart_write   (uart_write),
        .uart_o_data  (uart_o_data),
        .uart_accepted(uart_accepted),
        .uart_done    (uart_done),
        .uart_r_data  (uart_r_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_overflow  (rx_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag, output logic [31:0] rd);
        bit seen;
        seen = 1'b0;
        rd   = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (uart_done) begin
                seen = 1'b1;
                rd   = uart_r_data;
            end
        end
        check_eq({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    endtask

    // Issue a read, then supply the bytes of word low byte first.
    task automatic rx_read(input logic [1:0] size, input logic [31:0] word, input int n,
                           input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        uart_order = 1'b1;
        uart_write = 1'b0;
        uart_size  = size;
        step();
        check_eq({tag, "_acc"}, {31'b0, uart_accepted}, 32'd1);
        uart_order = 1'b0;
        for (int i = 0; i < n; i++) push(word[8*i +: 8]);
        wait_done(20, tag, rd);
        check_eq({tag, "_rdata"}, rd, exp);
    endtask

    logic [7:0]  bp_bytes [4];
    logic [31:0] rd;
    int          done_cnt;
    int          acc_cnt;
    int          last_acc;
    int          min_gap;
    int          coinc;

    initial begin
        rst         = 1'b1;
        uart_order  = 1'b0;
        uart_size   = 2'b00;
        uart_write  = 1'b0;
        uart_o_data = '0;
        tx_ready    = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        step();
        step();
        check_eq("rst_accepted", {31'b0, uart_accepted}, 32'd0);
        check_eq("rst_done", {31'b0, uart_done}, 32'd0);
        check_eq("rst_rdata", uart_r_data, 32'd0);
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check_eq("rst_overflow", {31'b0, rx_overflow}, 32'd0);

        // 1-byte write accepted in the first cycle after reset.
        rst         = 1'b0;
        uart_order  = 1'b1;
        uart_write  = 1'b1;
        uart_size   = 2'b10;
        uart_o_data = 32'h0000_00aa;
        tx_ready    = 1'b1;
        step();
        check_eq("wr1_acc", {31'b0, uart_accepted}, 32'd1);
        check_eq("wr1_no_early_valid", {31'b0, tx_valid}, 32'd0);
        uart_order = 1'b0;
        step();
        check_eq("wr1_valid", {31'b0, tx_valid}, 32'd1);
        check_eq("wr1_data", {24'b0, tx_data}, 32'h aa);
        check_eq("wr1_acc_pulse", {31'b0, uart_accepted}, 32'd0);
        step();
        check_eq("wr1_done_n2", {31'b0, uart_done}, 32'd0);
        check_eq("wr1_valid_drop", {31'b0, tx_valid}, 32'd0);
        step();
        check_eq("wr1_done_n3", {31'b0, uart_done}, 32'd1);
        check_eq("wr1_rdata", uart_r_data, 32'd0);
        step();
        check_eq("wr1_done_pulse", {31'b0, uart_done}, 32'd0);

        // 4-byte read.
`ifdef UART_RX_FIFO_EN
        push(8'h78);
        push(8'h56);
        push(8'h34);
        push(8'h12);
        uart_order = 1'b1;
        uart_write = 1'b0;
        uart_size  = 2'b00;
        step();
        check_eq("rd4_acc", {31'b0, uart_accepted}, 32'd1);
        uart_order = 1'b0;
        wait_done(20, "rd4", rd);
        check_eq("rd4_rdata", rd, 32'h1234_5678);
`else
        rx_read(2'b00, 32'h1234_5678, 4, 32'h1234_5678, "rd4");
`endif
        check_eq("rd4_no_ovf", {31'b0, rx_overflow}, 32'd0);
        rx_read(2'b01, 32'hffff_b2a1, 2, 32'h0000_b2a1, "rd2");
        rx_read(2'b11, 32'h0bad_cafe, 4, 32'h0bad_cafe, "rd4s11");
        check_eq("rd_no_ovf", {31'b0, rx_overflow}, 32'd0);

        // 4-byte write with backpressure.
        bp_bytes[0] = 8'hef;
        bp_bytes[1] = 8'hbe;
        bp_bytes[2] = 8'had;
        bp_bytes[3] = 8'hde;
        tx_ready    = 1'b0;
        uart_order  = 1'b1;
        uart_write  = 1'b1;
        uart_size   = 2'b00;
        uart_o_data = 32'hdead_beef;
        step();
        check_eq("bp_acc", {31'b0, uart_accepted}, 32'd1);
        uart_order = 1'b0;
        done_cnt   = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_valid", {31'b0, tx_valid}, 32'd1);
            check_eq("bp_hold_data", {24'b0, tx_data}, 32'h ef);
            if (uart_done) done_cnt++;
            if (i < 4) step();
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_valid", {31'b0, tx_valid}, 32'd1);
            check_eq("bp_byte", {24'b0, tx_data}, {24'b0, bp_bytes[i]});
            step();
            if (uart_done) done_cnt++;
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (uart_done) done_cnt++;
        end
        check_eq("bp_done_count", done_cnt, 32'd1);

        // Overflow with no request pending.
        do_reset();
        for (int i = 0; i < Depth; i++) push(8'(8'h10 + i));
        check_eq("ovf_not_yet", {31'b0, rx_overflow}, 32'd0);
        push(8'(8'h10 + Depth));
        check_eq("ovf_set", {31'b0, rx_overflow}, 32'd1);
        uart_order = 1'b1;
        uart_write = 1'b0;
        uart_size  = 2'b10;
        step();
        check_eq("ovf_rd_acc", {31'b0, uart_accepted}, 32'd1);
        uart_order = 1'b0;
        wait_done(20, "ovf_rd", rd);
        check_eq("ovf_first_byte", rd, 32'h10);
        check_eq("ovf_sticky", {31'b0, rx_overflow}, 32'd1);
        do_reset();
        check_eq("ovf_cleared", {31'b0, rx_overflow}, 32'd0);

        // Reset in the middle of a 4-byte read.
        uart_order = 1'b1;
        uart_write = 1'b0;
        uart_size  = 2'b00;
        step();
        check_eq("mid_acc", {31'b0, uart_accepted}, 32'd1);
        uart_order = 1'b0;
        push(8'h01);
        push(8'h02);
        step();
        rst = 1'b1;
        step();
        check_eq("mid_rst_done", {31'b0, uart_done}, 32'd0);
        check_eq("mid_rst_rdata", uart_r_data, 32'd0);
        check_eq("mid_rst_acc", {31'b0, uart_accepted}, 32'd0);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (uart_done) done_cnt++;
        end
        check_eq("mid_no_done", done_cnt, 32'd0);
        uart_order = 1'b1;
        uart_size  = 2'b10;
        step();
        check_eq("mid_fresh_acc", {31'b0, uart_accepted}, 32'd1);
        uart_order = 1'b0;
        done_cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (uart_done) done_cnt++;
        end
        check_eq("mid_fifo_empty", done_cnt, 32'd0);
        push(8'h5a);
        wait_done(20, "mid_fresh", rd);
        check_eq("mid_fresh_rdata", rd, 32'h5a);

        // Back-to-back 1-byte reads with order held high.
        do_reset();
        acc_cnt    = 0;
        last_acc   = -1;
        min_gap    = 1000;
        coinc      = 0;
        uart_order = 1'b1;
        uart_write = 1'b0;
        uart_size  = 2'b10;
        rx_valid   = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            rx_data = 8'(cyc);
            step();
            if (uart_accepted && uart_done) coinc++;
            if (uart_accepted) begin
                acc_cnt++;
                if (last_acc >= 0 && (cyc - last_acc) < min_gap) min_gap = cyc - last_acc;
                last_acc = cyc;
            end
        end
        uart_order = 1'b0;
        rx_valid   = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("b2b_count", {31'b0, acc_cnt >= 5}, 32'd1);
        check_eq("b2b_min_gap", {31'b0, min_gap >= 3}, 32'd1);
        check_eq("b2b_coincident", coinc, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
